// File: rtl/keep_pkg.sv
// Shared constants for the denomination decoder: word values, LED patterns
// and the controller state encoding.
package keep_pkg;

    localparam logic [10:0] VAL_C0 = 11'd5;
    localparam logic [10:0] VAL_C1 = 11'd10;
    localparam logic [10:0] VAL_C2 = 11'd15;
    localparam logic [10:0] VAL_C3 = 11'd20;

    // LED patterns are ordered {LED2, LED1, LED0}
    localparam logic [2:0] LED_C0  = 3'b001;
    localparam logic [2:0] LED_C1  = 3'b010;
    localparam logic [2:0] LED_C2  = 3'b100;
    localparam logic [2:0] LED_C3  = 3'b011;
    localparam logic [2:0] LED_OFF = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/keep_value_decode.sv
// Combinational map from an 11-bit denomination word to its selection code
// and LED pattern; anything outside the four denominations is illegal.
module keep_value_decode
    import keep_pkg::*;
(
    input  logic [10:0] value_i,
    output logic        legal_o,
    output logic [1:0]  code_o,
    output logic [2:0]  led_o
);

    always_comb begin
        legal_o = 1'b1;
        code_o  = '0;
        led_o   = LED_OFF;
        case (value_i)
            VAL_C0: begin code_o = 2'd0; led_o = LED_C0; end
            VAL_C1: begin code_o = 2'd1; led_o = LED_C1; end
            VAL_C2: begin code_o = 2'd2; led_o = LED_C2; end
            VAL_C3: begin code_o = 2'd3; led_o = LED_C3; end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keep_decode.sv
// Receive-side denomination decoder: handshake accept, code/LED indication
// held for HOLD_CYCLES, error blink, and a saturating running total.
module keep_decode
    import keep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [10:0]        in_value,
    output logic               in_ready,
    input  logic               clr_total,
    output logic [1:0]         code,
    output logic               code_valid,
    output logic               err,
    output logic               LED0,
    output logic               LED1,
    output logic               LED2,
    output logic [TOTAL_W-1:0] total
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         code_q, code_d;
    logic               code_valid_q, code_valid_d;
    logic               err_q, err_d;
    logic [2:0]         led_q, led_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic               dec_legal;
    logic [1:0]         dec_code;
    logic [2:0]         dec_led;
    logic               accept;
    logic [TOTAL_W:0]   sum;

    keep_value_decode u_value_decode (
        .value_i (in_value),
        .legal_o (dec_legal),
        .code_o  (dec_code),
        .led_o   (dec_led)
    );

    assign in_ready = (state_q != ST_ERR);
    assign accept   = in_valid && in_ready;
    // One extra bit so a carry out of the total can be detected and clamped
    assign sum      = {1'b0, total_q} + (TOTAL_W + 1)'(in_value);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        total_d      = total_q;
        led_d        = LED_OFF;

        if (accept && dec_legal) begin
            state_d      = ST_SHOW;
            cnt_d        = CNT_LOAD;
            code_d       = dec_code;
            code_valid_d = 1'b1;
            total_d      = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        end else if (accept) begin
            state_d = ST_ERR;
            cnt_d   = CNT_LOAD;
            err_d   = 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (clr_total) begin
            total_d = '0;
        end

        // LEDs are computed from the next state so they are plain flops
        case (state_d)
            ST_SHOW: led_d = (accept && dec_legal) ? dec_led : led_q;
            ST_ERR:  led_d = {3{cnt_d[0]}};
            default: led_d = LED_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            led_q        <= LED_OFF;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
            led_q        <= led_d;
            total_q      <= total_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign err        = err_q;
    assign LED0       = led_q[0];
    assign LED1       = led_q[1];
    assign LED2       = led_q[2];
    assign total      = total_q;

endmodule

// File: tb/tb_keep_decode.sv
// Directed vector bench for keep_decode: default instance driven from a
// cycle table, plus a HOLD_CYCLES=1 / TOTAL_W=5 instance for boundaries.
module tb_keep_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults)
    logic        rst_n, in_valid, clr_total;
    logic [10:0] in_value;
    logic        in_ready, code_valid, err, LED0, LED1, LED2;
    logic [1:0]  code;
    logic [15:0] total;

    // Small instance (HOLD_CYCLES=1, TOTAL_W=5)
    logic        s_rst_n, s_in_valid, s_clr_total;
    logic [10:0] s_in_value;
    logic        s_in_ready, s_code_valid, s_err, s_LED0, s_LED1, s_LED2;
    logic [1:0]  s_code;
    logic [4:0]  s_total;

    keep_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
        .in_ready(in_ready), .clr_total(clr_total), .code(code),
        .code_valid(code_valid), .err(err), .LED0(LED0), .LED1(LED1),
        .LED2(LED2), .total(total)
    );

    keep_decode #(.HOLD_CYCLES(1), .TOTAL_W(5)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_value(s_in_value),
        .in_ready(s_in_ready), .clr_total(s_clr_total), .code(s_code),
        .code_valid(s_code_valid), .err(s_err), .LED0(s_LED0), .LED1(s_LED1),
        .LED2(s_LED2), .total(s_total)
    );

    typedef struct {
        logic        v;
        logic [10:0] val;
        logic        clr;
        logic [1:0]  code;
        logic        cv;
        logic        er;
        logic [2:0]  led;
        logic [15:0] tot;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic add(input logic v, input logic [10:0] val, input logic clr,
                       input logic [1:0] c, input logic cv, input logic er,
                       input logic [2:0] led, input logic [15:0] tot, input logic rdy);
        vec_t r;
        r.v = v; r.val = val; r.clr = clr; r.code = c; r.cv = cv; r.er = er;
        r.led = led; r.tot = tot; r.rdy = rdy;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int idx, input logic [1:0] c,
                            input logic cv, input logic er, input logic [2:0] led,
                            input logic [15:0] tot, input logic rdy);
        chk({tag, ".code"}, idx, 32'(code), 32'(c));
        chk({tag, ".code_valid"}, idx, 32'(code_valid), 32'(cv));
        chk({tag, ".err"}, idx, 32'(err), 32'(er));
        chk({tag, ".leds"}, idx, 32'({LED2, LED1, LED0}), 32'(led));
        chk({tag, ".total"}, idx, 32'(total), 32'(tot));
        chk({tag, ".in_ready"}, idx, 32'(in_ready), 32'(rdy));
    endtask

    task automatic chk_small(input string tag, input int idx, input logic [1:0] c,
                             input logic cv, input logic er, input logic [2:0] led,
                             input logic [4:0] tot, input logic rdy);
        chk({tag, ".code"}, idx, 32'(s_code), 32'(c));
        chk({tag, ".code_valid"}, idx, 32'(s_code_valid), 32'(cv));
        chk({tag, ".err"}, idx, 32'(s_err), 32'(er));
        chk({tag, ".leds"}, idx, 32'({s_LED2, s_LED1, s_LED0}), 32'(led));
        chk({tag, ".total"}, idx, 32'(s_total), 32'(tot));
        chk({tag, ".in_ready"}, idx, 32'(s_in_ready), 32'(rdy));
    endtask

    task automatic s_step(input logic v, input logic [10:0] val, input logic clr);
        s_in_valid = v; s_in_value = val; s_clr_total = clr;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; clr_total = 1'b0;
        s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_value = '0; s_clr_total = 1'b0;

        // Expected values are the outputs just after each rising edge
        add(1, 10, 0, 1, 1, 0, 3'b010, 10, 1);
        for (int i = 0; i < 7; i++) add(0, 11'h7ff, 0, 1, 0, 0, 3'b010, 10, 1);
        add(0, 0, 0, 1, 0, 0, 3'b000, 10, 1);
        add(1, 5, 0, 0, 1, 0, 3'b001, 15, 1);
        add(1, 20, 0, 3, 1, 0, 3'b011, 35, 1);
        add(1, 15, 0, 2, 1, 0, 3'b100, 50, 1);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 2, 0, 0, 3'b100, 50, 1);
        add(0, 0, 0, 2, 0, 0, 3'b000, 50, 1);
        add(1, 7, 0, 2, 0, 1, 3'b111, 50, 0);
        for (int i = 0; i < 7; i++)
            add(1, 5, 0, 2, 0, 0, ((6 - i) % 2 == 1) ? 3'b111 : 3'b000, 50, 0);
        add(1, 5, 0, 2, 0, 0, 3'b000, 50, 1);
        add(1, 5, 0, 0, 1, 0, 3'b001, 55, 1);
        add(1, 10, 1, 1, 1, 0, 3'b010, 0, 1);
        add(1, 0, 0, 1, 0, 1, 3'b111, 0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 1, 0, 0, ((6 - i) % 2 == 1) ? 3'b111 : 3'b000, 0, 0);
        add(0, 0, 0, 1, 0, 0, 3'b000, 0, 1);
        add(1, 20, 0, 3, 1, 0, 3'b011, 20, 1);

        #12;
        chk_main("reset", 0, 2'd0, 0, 0, 3'b000, 16'd0, 1);
        chk_small("s_reset", 0, 2'd0, 0, 0, 3'b000, 5'd0, 1);
        rst_n = 1'b1;
        s_rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; in_value = vecs[i].val; clr_total = vecs[i].clr;
            @(posedge clk); #1;
            chk_main("vec", i, vecs[i].code, vecs[i].cv, vecs[i].er, vecs[i].led,
                     vecs[i].tot, vecs[i].rdy);
        end

        // Asynchronous reset in the middle of SHOW (LEDs 011)
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_main("async_rst", 0, 2'd0, 0, 0, 3'b000, 16'd0, 1);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_value = 11'd15;
        @(posedge clk); #1;
        chk_main("post_rst", 0, 2'd2, 1, 0, 3'b100, 16'd15, 1);
        in_valid = 1'b0;

        // HOLD_CYCLES=1, TOTAL_W=5: saturation, clear priority, one-cycle states
        s_step(1, 20, 0); chk_small("sat", 0, 2'd3, 1, 0, 3'b011, 5'd20, 1);
        s_step(1, 20, 0); chk_small("sat", 1, 2'd3, 1, 0, 3'b011, 5'd31, 1);
        s_step(0, 0, 0);  chk_small("hold1", 0, 2'd3, 0, 0, 3'b000, 5'd31, 1);
        s_step(1, 5, 1);  chk_small("clr", 0, 2'd0, 1, 0, 3'b001, 5'd0, 1);
        s_step(1, 9, 0);  chk_small("err1", 0, 2'd0, 0, 1, 3'b000, 5'd0, 0);
        s_step(1, 10, 0); chk_small("err1", 1, 2'd0, 0, 0, 3'b000, 5'd0, 1);
        s_step(1, 10, 0); chk_small("err1", 2, 2'd1, 1, 0, 3'b010, 5'd10, 1);
        s_step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
